mole_round_controller: RTL and testbench
========================================

# mole_round_controller

Round sequencer for the whack-a-mole game. It drives the `mole_position` block's `i_change_position` strobe, times how long each mole stays up, judges player whacks against the current mole position, and keeps score and miss counts. It sits between the debounced button/switch decoder (whack requests) and the display/score logic, and is the only block allowed to move the mole.

## Interface
Parameters:
- `INIT_PERIOD`, 100: cycles a mole stays up in the first round.
- `MIN_PERIOD`, 20: floor for the up period.
- `PERIOD_STEP`, 10: up-period reduction applied after each hit.
- `GAP_CYCLES`, 8: hidden cycles between moles.
- `MAX_MISSES`, 3: miss count that ends the game.
- `PERIOD_W`, 24: width of the period register and the timer.

Ports:
- `i_clk`  in  1  system clock; single clock domain.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_start`  in  1  one-cycle start pulse; honoured only in IDLE or OVER.
- `i_whack_valid`  in  1  one-cycle whack request.
- `i_whack_pos`  in  3  hole being whacked.
- `i_mole_pos`  in  3  current hole, taken from `mole_position.o_mole_position`.
- `o_change_position`  out  1  one-cycle strobe to `mole_position.i_change_position`.
- `o_mole_visible`  out  1  high while the mole is up.
- `o_score`  out  8  hit count; saturates at 255.
- `o_misses`  out  4  miss count.
- `o_game_over`  out  1  high in OVER.
- `o_state`  out  3  state encoding, for debug and LEDs.

## Operation
- States: IDLE, SPAWN, SETTLE, UP, HIT, MISS, GAP, OVER.
- All outputs are Moore outputs, decoded from the state register or taken directly from registers.
- IDLE: waits for `i_start`. On start:
  - clear `o_score` and `o_misses`;
  - set period to `INIT_PERIOD`;
  - go to SPAWN.
- SPAWN: `o_change_position`=1 for exactly one cycle, then go to SETTLE.
- SETTLE: one cycle so that `i_mole_pos` reflects the new hole. Load the timer with period−1, then go to UP.
- UP: `o_mole_visible`=1 and the timer decrements each cycle.
  - A matching whack (`i_whack_valid` high and `i_whack_pos`==`i_mole_pos`) goes to HIT.
  - Otherwise, when the timer is 0, go to MISS.
  - A non-matching whack is ignored.
- HIT: one cycle.
  - `o_score` += 1, saturating at 255.
  - period = max(period−`PERIOD_STEP`, `MIN_PERIOD`). Compute the subtraction at width `PERIOD_W`+1 so it cannot underflow.
  - Then go to GAP.
- MISS: one cycle. `o_misses` += 1. If the new value equals `MAX_MISSES`, go to OVER; otherwise go to GAP.
- GAP: load the timer with `GAP_CYCLES`−1. Mole hidden, whacks ignored. Go to SPAWN when the timer is 0.
- OVER: `o_game_over`=1. Score and misses hold. `i_start` clears score and misses, reloads the period, and goes to SPAWN.
- Boundary rules:
  - A matching whack on the same cycle the timer hits 0 counts as a HIT.
  - `i_start` outside IDLE and OVER is ignored.
  - Whacks outside UP are ignored.
  - Score holds at 255 on further hits.
- Reset, including mid-round: state=IDLE, timer=0, period=`INIT_PERIOD`. All outputs 0; `o_state` shows the IDLE code 0.

## Timing
- `i_start` sampled high in cycle N:
  - N+1: SPAWN, strobe high;
  - N+2: SETTLE;
  - N+3: first UP cycle.
- UP lasts exactly period cycles when there is no hit.
- Matching whack in UP cycle k:
  - HIT in k+1;
  - updated `o_score` visible in k+2;
  - GAP starts in k+2.
- GAP lasts `GAP_CYCLES` cycles, then SPAWN. The mole-to-mole period after a timeout is period + `GAP_CYCLES` + 3.
- There is exactly one `o_change_position` pulse per mole, never on back-to-back cycles.

## Structure
- Shared package `mole_pkg`:
  - state encoding localparams: IDLE=0, SPAWN=1, SETTLE=2, UP=3, HIT=4, MISS=5, GAP=6, OVER=7;
  - default parameter values;
  - the hole-index width (3).
- Sub-module `mole_timer`: a loadable `PERIOD_W` down-counter with inputs `load`, `value` and `en`, and a `zero` flag. It is shared by UP and GAP.
- Top level contains the FSM, the period register and the score/miss registers.

## Test plan
All scenarios use test parameters INIT_PERIOD=10, MIN_PERIOD=4, PERIOD_STEP=3, GAP_CYCLES=2, MAX_MISSES=3.
- Reset then start pulse → `o_change_position` high in exactly one cycle (N+1); `o_mole_visible` high for 10 cycles from N+3; then MISS, and `o_misses`=1.
- Matching whack in the 3rd UP cycle → `o_score`=1. The next UP lasts 7 cycles; after further hits it lasts 4, 4, 4 (floored).
- Non-matching whack in UP, plus a whack during GAP → both ignored; score unchanged; timeout still produces a MISS.
- Three timeouts → `o_game_over`=1 and `o_misses`=3. Start from OVER → misses=0, score=0, SPAWN in the next cycle.
- Matching whack on the last UP cycle (timer 0) → HIT, not MISS.
- `i_rst` asserted during UP → next cycle state=IDLE and all outputs 0. Start afterwards → UP length 10.

Source files
------------

// File: rtl/mole_pkg.sv
// Shared definitions for the whack-a-mole round sequencer: state codes, hole width, defaults.
// Latency: none (types and constants only).
// Backpressure: not applicable.
package mole_pkg;

    // Width of a hole index coming from the mole_position block.
    localparam int HOLE_W  = 3;
    localparam int STATE_W = 3;

    // State codes, also shown on o_state for debug LEDs.
    localparam logic [STATE_W-1:0] IDLE_CODE   = 3'd0;
    localparam logic [STATE_W-1:0] SPAWN_CODE  = 3'd1;
    localparam logic [STATE_W-1:0] SETTLE_CODE = 3'd2;
    localparam logic [STATE_W-1:0] UP_CODE     = 3'd3;
    localparam logic [STATE_W-1:0] HIT_CODE    = 3'd4;
    localparam logic [STATE_W-1:0] MISS_CODE   = 3'd5;
    localparam logic [STATE_W-1:0] GAP_CODE    = 3'd6;
    localparam logic [STATE_W-1:0] OVER_CODE   = 3'd7;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = IDLE_CODE,
        ST_SPAWN  = SPAWN_CODE,
        ST_SETTLE = SETTLE_CODE,
        ST_UP     = UP_CODE,
        ST_HIT    = HIT_CODE,
        ST_MISS   = MISS_CODE,
        ST_GAP    = GAP_CODE,
        ST_OVER   = OVER_CODE
    } state_t;

    // Default game tuning.
    localparam int DEF_INIT_PERIOD = 100;
    localparam int DEF_MIN_PERIOD  = 20;
    localparam int DEF_PERIOD_STEP = 10;
    localparam int DEF_GAP_CYCLES  = 8;
    localparam int DEF_MAX_MISSES  = 3;
    localparam int DEF_PERIOD_W    = 24;

endpackage

// File: rtl/mole_timer.sv
// Loadable down-counter shared by the mole-up window and the hidden gap; zero flag is registered-count decode.
// Latency: load takes effect the cycle after it is asserted; zero reflects the current count.
// Backpressure: none; en simply pauses the count, which also holds at zero.
module mole_timer #(
    parameter int W = 24
) (
    input  logic         core_clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] value,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority over counting; the count never wraps below zero.
    always_ff @(posedge core_clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= value;
        end else if (en && (count != '0)) begin
            count <= count - W'(1);
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/mole_round_controller.sv
// Round sequencer: spawns moles, times the up window, judges whacks, keeps score and misses.
// Latency: start -> SPAWN next cycle; matching whack -> HIT next cycle, score visible the cycle after.
// Backpressure: none; whacks outside UP and starts outside IDLE/OVER are dropped.
module mole_round_controller
    import mole_pkg::*;
#(
    parameter int INIT_PERIOD = DEF_INIT_PERIOD,
    parameter int MIN_PERIOD  = DEF_MIN_PERIOD,
    parameter int PERIOD_STEP = DEF_PERIOD_STEP,
    parameter int GAP_CYCLES  = DEF_GAP_CYCLES,
    parameter int MAX_MISSES  = DEF_MAX_MISSES,
    parameter int PERIOD_W    = DEF_PERIOD_W
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_start,
    input  logic              i_whack_valid,
    input  logic [HOLE_W-1:0] i_whack_pos,
    input  logic [HOLE_W-1:0] i_mole_pos,
    output logic              o_change_position,
    output logic              o_mole_visible,
    output logic [7:0]        o_score,
    output logic [3:0]        o_misses,
    output logic              o_game_over,
    output logic [2:0]        o_state
);

    state_t              state;
    logic [PERIOD_W-1:0] period;
    logic [7:0]          score;
    logic [3:0]          misses;

    logic                timer_load;
    logic [PERIOD_W-1:0] timer_value;
    logic                timer_en;
    logic                timer_zero;

    logic                whack_hit;
    logic [PERIOD_W:0]   period_diff;
    logic [PERIOD_W-1:0] period_dec;
    logic [3:0]          misses_inc;

    assign whack_hit = i_whack_valid && (i_whack_pos == i_mole_pos);

    // One extra bit so a step larger than the current period shows up as a borrow.
    assign period_diff = {1'b0, period} - (PERIOD_W + 1)'(PERIOD_STEP);
    assign period_dec  = (period_diff[PERIOD_W] ||
                          (period_diff[PERIOD_W-1:0] < PERIOD_W'(MIN_PERIOD)))
                         ? PERIOD_W'(MIN_PERIOD) : period_diff[PERIOD_W-1:0];

    assign misses_inc = misses + 4'd1;

    // Timer is armed one cycle ahead of the window it measures: in SETTLE for UP, in HIT/MISS for GAP.
    always_comb begin
        timer_load  = 1'b0;
        timer_value = '0;
        timer_en    = (state == ST_UP) || (state == ST_GAP);
        if (state == ST_SETTLE) begin
            timer_load  = 1'b1;
            timer_value = period - PERIOD_W'(1);
        end else if ((state == ST_HIT) || (state == ST_MISS)) begin
            timer_load  = 1'b1;
            timer_value = PERIOD_W'(GAP_CYCLES - 1);
        end
    end

    mole_timer #(
        .W (PERIOD_W)
    ) u_timer (
        .core_clk (i_clk),
        .rst      (i_rst),
        .load     (timer_load),
        .value    (timer_value),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    // Round FSM with the period, score and miss registers; a hit on the last UP cycle beats the timeout.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state  <= ST_IDLE;
            period <= PERIOD_W'(INIT_PERIOD);
            score  <= '0;
            misses <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_OVER: begin
                    if (i_start) begin
                        score  <= '0;
                        misses <= '0;
                        period <= PERIOD_W'(INIT_PERIOD);
                        state  <= ST_SPAWN;
                    end
                end
                ST_SPAWN:  state <= ST_SETTLE;
                ST_SETTLE: state <= ST_UP;
                ST_UP: begin
                    if (whack_hit) begin
                        state <= ST_HIT;
                    end else if (timer_zero) begin
                        state <= ST_MISS;
                    end
                end
                ST_HIT: begin
                    if (score != 8'hFF) begin
                        score <= score + 8'd1;
                    end
                    period <= period_dec;
                    state  <= ST_GAP;
                end
                ST_MISS: begin
                    misses <= misses_inc;
                    state  <= (misses_inc == 4'(MAX_MISSES)) ? ST_OVER : ST_GAP;
                end
                ST_GAP: begin
                    if (timer_zero) begin
                        state <= ST_SPAWN;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign o_change_position = (state == ST_SPAWN);
    assign o_mole_visible    = (state == ST_UP);
    assign o_game_over       = (state == ST_OVER);
    assign o_score           = score;
    assign o_misses          = misses;
    assign o_state           = state;

endmodule

// File: tb/tb_mole_round_controller.sv
// Directed bench for mole_round_controller with a timeline model of the round schedule.
// Latency: n/a.
// Backpressure: n/a.
module tb_mole_round_controller;

    localparam int INIT_P = 10;
    localparam int MIN_P  = 4;
    localparam int STEP_P = 3;
    localparam int GAP_P  = 2;
    localparam int MAXM   = 3;

    localparam int S_IDLE = 0, S_SPAWN = 1, S_SETTLE = 2, S_UP = 3;
    localparam int S_HIT = 4, S_MISS = 5, S_GAP = 6, S_OVER = 7;

    logic       clk = 1'b0;
    logic       rst, start, wv;
    logic [2:0] wp, mole_pos;
    logic       chg, vis, over;
    logic [7:0] score;
    logic [3:0] misses;
    logic [2:0] st;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mole_round_controller #(
        .INIT_PERIOD (INIT_P),
        .MIN_PERIOD  (MIN_P),
        .PERIOD_STEP (STEP_P),
        .GAP_CYCLES  (GAP_P),
        .MAX_MISSES  (MAXM),
        .PERIOD_W    (24)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_start           (start),
        .i_whack_valid     (wv),
        .i_whack_pos       (wp),
        .i_mole_pos        (mole_pos),
        .o_change_position (chg),
        .o_mole_visible    (vis),
        .o_score           (score),
        .o_misses          (misses),
        .o_game_over       (over),
        .o_state           (st)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Timeline model: a round is a spawn time plus a resolve time; everything else is arithmetic on those.
    bit m_known = 0, m_active = 0, m_over = 0, m_hit = 0;
    int m_score = 0, m_misses = 0, m_period = INIT_P, m_spawn = 0, m_end = -1;
    int cyc = 0;
    int exp_st;
    int run = 0;
    int up_lens[$];

    function automatic int model_state(input int t);
        int rel;
        if (!m_active) return m_over ? S_OVER : S_IDLE;
        rel = t - m_spawn;
        if (rel == 0) return S_SPAWN;
        if (rel == 1) return S_SETTLE;
        if (m_end < 0 || t < m_end) return S_UP;
        if (t == m_end) return m_hit ? S_HIT : S_MISS;
        return S_GAP;
    endfunction

    initial begin
        forever begin
            @(negedge clk);
            exp_st = model_state(cyc);
            if (m_known) begin
                chk("state", int'(st), exp_st);
                chk("change_position", int'(chg), int'(exp_st == S_SPAWN));
                chk("mole_visible", int'(vis), int'(exp_st == S_UP));
                chk("game_over", int'(over), int'(exp_st == S_OVER));
                chk("score", int'(score), m_score);
                chk("misses", int'(misses), m_misses);
            end
            if (vis) begin
                run++;
            end else if (run > 0) begin
                up_lens.push_back(run);
                run = 0;
            end
            if (rst) begin
                m_known = 1; m_active = 0; m_over = 0; m_score = 0; m_misses = 0;
                m_period = INIT_P; m_end = -1;
            end else if (m_known) begin
                if (!m_active) begin
                    if (start) begin
                        m_active = 1; m_over = 0; m_score = 0; m_misses = 0;
                        m_period = INIT_P; m_spawn = cyc + 1; m_end = -1;
                    end
                end else begin
                    case (exp_st)
                        S_UP: begin
                            if (wv && wp == mole_pos) begin
                                m_end = cyc + 1; m_hit = 1;
                            end else if (cyc == m_spawn + 2 + m_period - 1) begin
                                m_end = cyc + 1; m_hit = 0;
                            end
                        end
                        S_HIT: begin
                            m_score  = (m_score < 255) ? m_score + 1 : 255;
                            m_period = (m_period - STEP_P < MIN_P) ? MIN_P : m_period - STEP_P;
                        end
                        S_MISS: begin
                            m_misses++;
                            if (m_misses == MAXM) begin
                                m_active = 0; m_over = 1;
                            end
                        end
                        S_GAP: begin
                            if (cyc == m_end + GAP_P) begin
                                m_spawn = cyc + 1; m_end = -1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            // Stand-in for the mole_position block: hop to a new hole on each strobe.
            if (chg) mole_pos = mole_pos + 3'd3;
            cyc++;
        end
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic whack(input logic [2:0] pos);
        wv = 1'b1;
        wp = pos;
        tick(1);
        wv = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick(1);
        start = 1'b0;
    endtask

    task automatic wait_vis();
        for (int i = 0; i < 50 && !vis; i++) tick(1);
        chk("wait_visible", int'(vis), 1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int exp_lens[9];
        exp_lens = '{10, 3, 7, 4, 4, 4, 4, 3, 10};
        rst = 1'b1; start = 1'b0; wv = 1'b0; wp = '0; mole_pos = 3'd1;
        tick(2);
        rst = 1'b0;
        chk("reset_state", int'(st), 0);
        chk("reset_score", int'(score), 0);
        chk("reset_misses", int'(misses), 0);

        // First mole times out.
        pulse_start();
        chk("n1_strobe", int'(chg), 1);
        chk("n1_state", int'(st), 1);
        tick(1);
        chk("n2_strobe_low", int'(chg), 0);
        chk("n2_state", int'(st), 2);
        tick(1);
        chk("n3_visible", int'(vis), 1);
        tick(9);
        chk("up_cycle10_visible", int'(vis), 1);
        tick(1);
        chk("timeout_miss", int'(st), 5);
        tick(1);
        chk("misses_after_timeout", int'(misses), 1);

        // Hit in the third UP cycle.
        wait_vis();
        tick(2);
        whack(mole_pos);
        chk("hit_state", int'(st), 4);
        tick(1);
        chk("score_after_hit", int'(score), 1);
        chk("gap_after_hit", int'(st), 6);

        // Hits on the last UP cycle (timer at zero): periods 7, 4, 4.
        wait_vis();
        tick(6);
        whack(mole_pos);
        chk("hit_at_zero_p7", int'(st), 4);
        wait_vis();
        tick(3);
        whack(mole_pos);
        chk("hit_at_zero_p4", int'(st), 4);
        wait_vis();
        tick(3);
        whack(mole_pos);
        chk("hit_at_zero_p4b", int'(st), 4);

        // Wrong hole during UP, right hole during GAP: both ignored.
        wait_vis();
        whack(mole_pos + 3'd1);
        tick(3);
        chk("nonmatch_timeout", int'(st), 5);
        tick(1);
        whack(mole_pos);
        chk("gap_whack_score", int'(score), 4);
        chk("gap_whack_misses", int'(misses), 2);

        // Third timeout ends the game.
        wait_vis();
        tick(4);
        chk("third_miss", int'(st), 5);
        tick(1);
        chk("game_over", int'(over), 1);
        chk("over_misses", int'(misses), 3);
        tick(3);
        chk("over_hold_score", int'(score), 4);

        // Restart from OVER.
        pulse_start();
        chk("restart_spawn", int'(st), 1);
        chk("restart_misses", int'(misses), 0);
        chk("restart_score", int'(score), 0);

        // Reset in the middle of UP.
        wait_vis();
        tick(2);
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        chk("midrst_state", int'(st), 0);
        chk("midrst_visible", int'(vis), 0);
        chk("midrst_strobe", int'(chg), 0);
        chk("midrst_over", int'(over), 0);
        chk("midrst_score", int'(score), 0);

        pulse_start();
        wait_vis();
        tick(10);
        chk("post_reset_up10_miss", int'(st), 5);

        // Score saturation.
        for (int i = 0; i < 260; i++) begin
            wait_vis();
            whack(mole_pos);
        end
        tick(2);
        chk("score_saturated", int'(score), 255);

        chk("up_len_count_ok", int'(up_lens.size() >= 9), 1);
        if (up_lens.size() >= 9) begin
            for (int i = 0; i < 9; i++) chk($sformatf("up_len_%0d", i), up_lens[i], exp_lens[i]);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
